// File: rtl/ex_stage_pkg.sv
// Shared widths, ALU opcode bit positions, divide function codes and bus layout
// for the execute stage.
package ex_stage_pkg;

  localparam int ID_TO_EX_WD  = 159;
  localparam int EX_TO_MEM_WD = 141;
  localparam int EX_TO_ID_WD  = 38;
  localparam int STALL_WD     = 6;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // One-hot alu_op bit positions, add is the MSB.
  localparam int ALU_ADD  = 11;
  localparam int ALU_SUB  = 10;
  localparam int ALU_SLT  = 9;
  localparam int ALU_SLTU = 8;
  localparam int ALU_AND  = 7;
  localparam int ALU_NOR  = 6;
  localparam int ALU_OR   = 5;
  localparam int ALU_XOR  = 4;
  localparam int ALU_SLL  = 3;
  localparam int ALU_SRL  = 2;
  localparam int ALU_SRA  = 1;
  localparam int ALU_LUI  = 0;

  localparam logic [5:0] FUNC_DIV  = 6'b011010;
  localparam logic [5:0] FUNC_DIVU = 6'b011011;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [11:0] alu_op;
    logic [2:0]  sel_alu_src1;
    logic [3:0]  sel_alu_src2;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        sel_rf_res;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
  } id_to_ex_t;

  function automatic logic is_div_inst(input logic [31:0] inst);
    return (inst[31:26] == 6'd0) && (inst[15:6] == 10'd0) &&
           ((inst[5:0] == FUNC_DIV) || (inst[5:0] == FUNC_DIVU));
  endfunction

endpackage

// File: rtl/div_iter.sv
// 32-step restoring divider with IDLE/BUSY/DONE FSM; results appear only in DONE
// and are held there until ack. The current state is exported on state.
module div_iter
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        ack,
  input  logic        signed_op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output div_state_e  state,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  div_state_e  state_q;
  logic [4:0]  count_q;
  logic [31:0] quo_q, rem_q, dvs_q;
  logic        neg_quo_q, neg_rem_q, dvz_q;
  logic [32:0] rem_shift, diff;

  assign rem_shift = {rem_q, quo_q[31]};
  assign diff      = rem_shift - {1'b0, dvs_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DIV_IDLE;
      count_q   <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dvz_q     <= 1'b0;
    end else begin
      unique case (state_q)
        DIV_IDLE: begin
          if (start) begin
            quo_q     <= (signed_op && dividend[31]) ? 32'd0 - dividend : dividend;
            dvs_q     <= (signed_op && divisor[31]) ? 32'd0 - divisor : divisor;
            rem_q     <= '0;
            count_q   <= '0;
            neg_quo_q <= signed_op && (dividend[31] ^ divisor[31]);
            neg_rem_q <= signed_op && dividend[31];
            dvz_q     <= (divisor == 32'd0);
            state_q   <= DIV_BUSY;
          end
        end
        DIV_BUSY: begin
          // diff[32] set means the trial subtraction borrowed: restore.
          if (!diff[32]) begin
            rem_q <= diff[31:0];
            quo_q <= {quo_q[30:0], 1'b1};
          end else begin
            rem_q <= rem_shift[31:0];
            quo_q <= {quo_q[30:0], 1'b0};
          end
          count_q <= count_q + 5'd1;
          if (count_q == 5'd31) state_q <= DIV_DONE;
        end
        DIV_DONE: begin
          if (ack) state_q <= DIV_IDLE;
        end
        default: state_q <= DIV_IDLE;
      endcase
    end
  end

  assign state = state_q;
  assign busy  = (state_q == DIV_BUSY);
  assign done  = (state_q == DIV_DONE);

  // Divide by zero keeps the all-ones quotient; the remainder already equals |dividend|.
  assign quotient  = !done ? 32'd0 :
                     (neg_quo_q && !dvz_q) ? 32'd0 - quo_q : quo_q;
  assign remainder = !done ? 32'd0 :
                     neg_rem_q ? 32'd0 - rem_q : rem_q;

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: input register, one-hot ALU, data SRAM request, forwarding.
// Defining EX_DIV_EN compiles in the iterative div/divu unit and its stall request.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_WD-1:0]     stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [EX_TO_ID_WD-1:0]  ex_to_id_bus,
  output logic                    inst_is_lw,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata,
  output logic                    stallreq_for_ex
);

  id_to_ex_t   id_q, id_d;
  logic [31:0] src1, src2, sum, dif, ex_result;
  logic [31:0] sll_res, srl_res, sra_res;
  logic [4:0]  shamt;
  logic        slt_res, sltu_res;
  logic        hilo_we;
  logic [31:0] hi, lo;
  logic        unused_bits;

  always_comb begin
    id_d = id_q;
    if (stall[2] == STOP && stall[3] == NO_STOP) id_d = '0;
    else if (stall[2] == NO_STOP)                id_d = id_to_ex_bus;
  end

  always_ff @(posedge clk) begin
    if (rst) id_q <= '0;
    else     id_q <= id_d;
  end

  assign src1 = ({32{id_q.sel_alu_src1[0]}} & id_q.rdata1)
              | ({32{id_q.sel_alu_src1[1]}} & id_q.pc)
              | ({32{id_q.sel_alu_src1[2]}} & {27'd0, id_q.inst[10:6]});
  assign src2 = ({32{id_q.sel_alu_src2[0]}} & id_q.rdata2)
              | ({32{id_q.sel_alu_src2[1]}} & {{16{id_q.inst[15]}}, id_q.inst[15:0]})
              | ({32{id_q.sel_alu_src2[2]}} & 32'd8)
              | ({32{id_q.sel_alu_src2[3]}} & {16'd0, id_q.inst[15:0]});

  assign sum      = src1 + src2;
  assign dif      = src1 - src2;
  assign slt_res  = $signed(src1) < $signed(src2);
  assign sltu_res = src1 < src2;
  assign shamt    = src1[4:0];
  assign sll_res  = src2 << shamt;
  assign srl_res  = src2 >> shamt;
  assign sra_res  = $signed(src2) >>> shamt;

  // alu_op is one-hot, so an AND-OR mux yields 0 when no op is selected.
  assign ex_result = ({32{id_q.alu_op[ALU_ADD]}}  & sum)
                   | ({32{id_q.alu_op[ALU_SUB]}}  & dif)
                   | ({32{id_q.alu_op[ALU_SLT]}}  & {31'd0, slt_res})
                   | ({32{id_q.alu_op[ALU_SLTU]}} & {31'd0, sltu_res})
                   | ({32{id_q.alu_op[ALU_AND]}}  & (src1 & src2))
                   | ({32{id_q.alu_op[ALU_NOR]}}  & ~(src1 | src2))
                   | ({32{id_q.alu_op[ALU_OR]}}   & (src1 | src2))
                   | ({32{id_q.alu_op[ALU_XOR]}}  & (src1 ^ src2))
                   | ({32{id_q.alu_op[ALU_SLL]}}  & sll_res)
                   | ({32{id_q.alu_op[ALU_SRL]}}  & srl_res)
                   | ({32{id_q.alu_op[ALU_SRA]}}  & sra_res)
                   | ({32{id_q.alu_op[ALU_LUI]}}  & {src2[15:0], 16'd0});

`ifdef EX_DIV_EN
  div_state_e div_state;
  logic       div_dec, div_busy, div_done;

  assign div_dec = is_div_inst(id_q.inst);

  div_iter u_div_iter (
    .clk       (clk),
    .rst       (rst),
    .start     (div_dec && (div_state == DIV_IDLE)),
    .ack       (stall[2] == NO_STOP),
    .signed_op (~id_q.inst[0]),
    .dividend  (id_q.rdata1),
    .divisor   (id_q.rdata2),
    .state     (div_state),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (lo),
    .remainder (hi)
  );

  assign stallreq_for_ex = ((div_state == DIV_IDLE) && div_dec) || div_busy;
  assign hilo_we         = div_done;
  assign unused_bits     = ^{stall[5:4], stall[1:0], id_q.inst[25:16]};
`else
  assign stallreq_for_ex = 1'b0;
  assign hilo_we         = 1'b0;
  assign hi              = '0;
  assign lo              = '0;
  assign unused_bits     = ^{stall[5:4], stall[1:0], id_q.inst[31:16], id_q.inst[5:0]};
`endif

  assign data_sram_en    = id_q.data_ram_en;
  assign data_sram_wen   = id_q.data_ram_wen;
  assign data_sram_addr  = ex_result;
  assign data_sram_wdata = id_q.rdata2;
  assign inst_is_lw      = id_q.sel_rf_res;

  assign ex_to_id_bus  = {id_q.rf_we, id_q.rf_waddr, ex_result};
  assign ex_to_mem_bus = {id_q.pc, id_q.data_ram_en, id_q.data_ram_wen, id_q.sel_rf_res,
                          id_q.rf_we, id_q.rf_waddr, ex_result, hilo_we, hi, lo};

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: reset, stall/bubble, ALU ops, SRAM request and,
// when EX_DIV_EN is defined, divider latency, hold, back-to-back and reset abort.
module tb_ex_stage;
  import ex_stage_pkg::*;

  localparam logic [11:0] OP_ADD  = 12'h800;
  localparam logic [11:0] OP_SUB  = 12'h400;
  localparam logic [11:0] OP_SLT  = 12'h200;
  localparam logic [11:0] OP_SLTU = 12'h100;
  localparam logic [11:0] OP_AND  = 12'h080;
  localparam logic [11:0] OP_NOR  = 12'h040;
  localparam logic [11:0] OP_OR   = 12'h020;
  localparam logic [11:0] OP_XOR  = 12'h010;
  localparam logic [11:0] OP_SLL  = 12'h008;
  localparam logic [11:0] OP_SRL  = 12'h004;
  localparam logic [11:0] OP_SRA  = 12'h002;
  localparam logic [11:0] OP_LUI  = 12'h001;

  logic                    clk;
  logic                    rst;
  logic [STALL_WD-1:0]     stall;
  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus;
  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
  logic [EX_TO_ID_WD-1:0]  ex_to_id_bus;
  logic                    inst_is_lw;
  logic                    data_sram_en;
  logic [3:0]              data_sram_wen;
  logic [31:0]             data_sram_addr;
  logic [31:0]             data_sram_wdata;
  logic                    stallreq_for_ex;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  ex_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .id_to_ex_bus    (id_to_ex_bus),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .ex_to_id_bus    (ex_to_id_bus),
    .inst_is_lw      (inst_is_lw),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .stallreq_for_ex (stallreq_for_ex)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [140:0] act, input logic [140:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [158:0] mk(input logic [31:0] pc, input logic [31:0] inst,
                                      input logic [11:0] op, input logic [2:0] s1,
                                      input logic [3:0] s2, input logic ren,
                                      input logic [3:0] rwen, input logic we,
                                      input logic [4:0] wa, input logic lw,
                                      input logic [31:0] r1, input logic [31:0] r2);
    return {pc, inst, op, s1, s2, ren, rwen, we, wa, lw, r1, r2};
  endfunction

  task automatic alu_vec(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                         input logic [11:0] op, input logic [2:0] s1, input logic [3:0] s2,
                         input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] exp);
    logic [31:0] e;
    stall        = 6'b000000;
    id_to_ex_bus = mk(pc, inst, op, s1, s2, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0, r1, r2);
    exp_q.push_back(exp);
    tick();
    e = exp_q.pop_front();
    check(tag, {109'd0, ex_to_id_bus[31:0]}, {109'd0, e});
  endtask

  // Act as the stall controller while the stage requests a stall; returns stalled cycles.
  task automatic run_div(output int cycles);
    cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (!stallreq_for_ex) break;
      cycles++;
      stall        = 6'b000111;
      id_to_ex_bus = '0;
      tick();
    end
    stall = 6'b000000;
  endtask

  logic [158:0] v_addiu, v_sw, v_lw, v_div, v_divu;
  int           cyc;

  initial begin
    v_addiu = mk(32'hBFC0_0000, 32'h2422_0001, OP_ADD, 3'b001, 4'b0010, 1'b0, 4'h0,
                 1'b1, 5'd2, 1'b0, 32'h7FFF_FFFF, 32'h0);
    v_sw    = mk(32'hBFC0_0004, 32'hAC22_FFFC, OP_ADD, 3'b001, 4'b0010, 1'b1, 4'hF,
                 1'b0, 5'd0, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF);
    v_lw    = mk(32'hBFC0_0008, 32'h8C27_0010, OP_ADD, 3'b001, 4'b0010, 1'b1, 4'h0,
                 1'b1, 5'd7, 1'b1, 32'h0000_0200, 32'h0);
    v_div   = mk(32'hBFC0_0100, 32'h0085_001A, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0,
                 1'b0, 5'd0, 1'b0, 32'hFFFF_FFF9, 32'h0000_0002);
    v_divu  = mk(32'hBFC0_0104, 32'h0085_001B, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0,
                 1'b0, 5'd0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000);

    // Reset: everything reads zero while rst is held, even with a valid input.
    rst          = 1'b1;
    stall        = 6'b000000;
    id_to_ex_bus = v_addiu;
    tick();
    tick();
    check("rst_mem_bus", ex_to_mem_bus, '0);
    check("rst_id_bus", {103'd0, ex_to_id_bus}, '0);
    check("rst_sram", {34'd0, data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}, '0);
    check("rst_lw", {140'd0, inst_is_lw}, '0);
    check("rst_stallreq", {140'd0, stallreq_for_ex}, '0);
    rst = 1'b0;

    // addiu overflow wraps without a trap.
    tick();
    check("addiu_id_bus", {103'd0, ex_to_id_bus}, {103'd0, 1'b1, 5'd2, 32'h8000_0000});
    check("addiu_mem_bus", ex_to_mem_bus,
          {32'hBFC0_0000, 1'b0, 4'h0, 1'b0, 1'b1, 5'd2, 32'h8000_0000, 1'b0, 32'h0, 32'h0});
    check("addiu_stallreq", {140'd0, stallreq_for_ex}, '0);

    // Stop on this stage and memory: hold. Stop here only: bubble.
    stall        = 6'b001111;
    id_to_ex_bus = v_sw;
    tick();
    check("hold_id_bus", {103'd0, ex_to_id_bus}, {103'd0, 1'b1, 5'd2, 32'h8000_0000});
    stall = 6'b000111;
    tick();
    check("bubble_mem_bus", ex_to_mem_bus, '0);

    // sw request
    stall = 6'b000000;
    tick();
    check("sw_sram", {34'd0, data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata},
          {34'd0, 1'b1, 4'hF, 32'h0000_00FC, 32'hDEAD_BEEF});

    // lw flags the load, then a bubble clears it.
    id_to_ex_bus = v_lw;
    tick();
    check("lw_is_lw", {140'd0, inst_is_lw}, {140'd0, 1'b1});
    check("lw_waddr", {136'd0, ex_to_id_bus[36:32]}, {136'd0, 5'd7});
    check("lw_sram", {104'd0, data_sram_en, data_sram_wen, data_sram_addr},
          {104'd0, 1'b1, 4'h0, 32'h0000_0210});
    id_to_ex_bus = '0;
    stall        = 6'b000011;
    tick();
    check("lw_bubble", {140'd0, inst_is_lw}, '0);

    // ALU vectors with hand-computed results.
    alu_vec("sub",    32'h0, 32'h0, OP_SUB,  3'b001, 4'b0001, 32'd5, 32'd7, 32'hFFFF_FFFE);
    alu_vec("slt_n",  32'h0, 32'h0, OP_SLT,  3'b001, 4'b0001, 32'hFFFF_FFFF, 32'd1, 32'd1);
    alu_vec("sltu_n", 32'h0, 32'h0, OP_SLTU, 3'b001, 4'b0001, 32'hFFFF_FFFF, 32'd1, 32'd0);
    alu_vec("slt_p",  32'h0, 32'h0, OP_SLT,  3'b001, 4'b0001, 32'd5, 32'hFFFF_FFFF, 32'd0);
    alu_vec("sltu_p", 32'h0, 32'h0, OP_SLTU, 3'b001, 4'b0001, 32'd5, 32'hFFFF_FFFF, 32'd1);
    alu_vec("and",    32'h0, 32'h0, OP_AND,  3'b001, 4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
    alu_vec("nor",    32'h0, 32'h0, OP_NOR,  3'b001, 4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F);
    alu_vec("or",     32'h0, 32'h0, OP_OR,   3'b001, 4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0);
    alu_vec("xor",    32'h0, 32'h0, OP_XOR,  3'b001, 4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
    alu_vec("sll_sa", 32'h0, 32'h0000_0100, OP_SLL, 3'b100, 4'b0001, 32'hFFFF_FFFF, 32'd1, 32'h0000_0010);
    alu_vec("sra_sa", 32'h0, 32'h0000_0100, OP_SRA, 3'b100, 4'b0001, 32'h0, 32'h8000_0000, 32'hF800_0000);
    alu_vec("srlv",   32'h0, 32'h0, OP_SRL,  3'b001, 4'b0001, 32'h0000_0024, 32'h8000_0000, 32'h0800_0000);
    alu_vec("lui",    32'h0, 32'h3C01_1234, OP_LUI, 3'b000, 4'b1000, 32'h0, 32'h0, 32'h1234_0000);
    alu_vec("ori",    32'h0, 32'h3422_FFFC, OP_OR,  3'b001, 4'b1000, 32'd3, 32'h0, 32'h0000_FFFF);
    alu_vec("link",   32'hBFC0_0010, 32'h0, OP_ADD, 3'b010, 4'b0100, 32'h0, 32'h0, 32'hBFC0_0018);
    alu_vec("add_wrap", 32'h0, 32'h0, OP_ADD, 3'b001, 4'b0001, 32'hFFFF_FFFF, 32'd2, 32'd1);
    alu_vec("no_op",  32'h0, 32'h0, 12'h000, 3'b001, 4'b0001, 32'd5, 32'd6, 32'd0);
    alu_vec("no_sel", 32'h0, 32'h0, OP_ADD,  3'b000, 4'b0000, 32'd5, 32'd6, 32'd0);

`ifdef EX_DIV_EN
    // div -7 / 2: 33 stalled cycles, then q=-3, r=-1.
    stall        = 6'b000000;
    id_to_ex_bus = v_div;
    tick();
    run_div(cyc);
    check("div_stall_cycles", {109'd0, cyc[31:0]}, {109'd0, 32'd33});
    check("div_result", {76'd0, ex_to_mem_bus[64:0]}, {76'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD});

    // Downstream stall during DONE holds the result.
    stall = 6'b001111;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("div_hold", {76'd0, ex_to_mem_bus[64:0]}, {76'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
      check("div_hold_stallreq", {140'd0, stallreq_for_ex}, '0);
    end

    // Back-to-back divu by zero.
    stall        = 6'b000000;
    id_to_ex_bus = v_divu;
    tick();
    check("divu_start", {140'd0, stallreq_for_ex}, {140'd0, 1'b1});
    run_div(cyc);
    check("divu_stall_cycles", {109'd0, cyc[31:0]}, {109'd0, 32'd33});
    check("divu_dvz_result", {76'd0, ex_to_mem_bus[64:0]}, {76'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF});

    // Reset at BUSY count 10 aborts.
    id_to_ex_bus = v_div;
    tick();
    for (int i = 0; i < 11; i++) begin
      stall        = 6'b000111;
      id_to_ex_bus = '0;
      tick();
    end
    check("abort_busy", {140'd0, stallreq_for_ex}, {140'd0, 1'b1});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_stallreq", {140'd0, stallreq_for_ex}, '0);
    stall = 6'b000000;
    tick();
    check("abort_idle", {139'd0, stallreq_for_ex, ex_to_mem_bus[64]}, '0);
`else
    // Without the divider, div is a no-op.
    stall        = 6'b000000;
    id_to_ex_bus = v_div;
    tick();
    check("div_nop_stallreq", {140'd0, stallreq_for_ex}, '0);
    check("div_nop_hilo", {76'd0, ex_to_mem_bus[64:0]}, '0);
    check("div_nop_result", {109'd0, ex_to_id_bus[31:0]}, '0);
`endif

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage MIPS pipeline, directly downstream of the decode stage. Latches the decode-to-execute bus, runs the single-cycle ALU, and issues the data SRAM request for `lw`/`sw`. Forwards its write-back result to decode and flags in-flight loads for load-use stalls. Contains an optional 32-cycle iterative divider for `div`/`divu` that stalls the pipeline while busy.

## Interface
Parameters: none. Widths come from `lib/defines.vh`.
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `stall`  in  `StallBus`  pipeline stall vector; bit 2 is this stage, bit 3 is memory; `Stop`=1
- `id_to_ex_bus`  in  `ID_TO_EX_WD` (159)  {pc[158:127], inst[126:95], alu_op[94:83], sel_alu_src1[82:80], sel_alu_src2[79:76], data_ram_en[75], data_ram_wen[74:71], rf_we[70], rf_waddr[69:65], sel_rf_res[64], rdata1[63:32], rdata2[31:0]}
- `ex_to_mem_bus`  out  `EX_TO_MEM_WD` (141)  {pc, data_ram_en, data_ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result, hilo_we, hi, lo}
- `ex_to_id_bus`  out  38  {rf_we, rf_waddr, ex_result}; forwarding path
- `inst_is_lw`  out  1  instruction currently in this stage is a load (`sel_rf_res`)
- `data_sram_en`  out  1  data SRAM enable
- `data_sram_wen`  out  4  byte write enables
- `data_sram_addr`  out  32  equals `ex_result`
- `data_sram_wdata`  out  32  equals `rdata2`
- `stallreq_for_ex`  out  1  divider busy; tells the controller to stall stages 0–2

## Operation
- Input register: on `rst`, cleared to 0. If `stall[2]`=Stop and `stall[3]`=NoStop, load a bubble (all zero). Else if `stall[2]`=NoStop, capture `id_to_ex_bus`. Otherwise hold.
- src1 is one-hot selected: [0] rdata1, [1] pc, [2] {27'b0, inst[10:6]}. src2 is one-hot selected: [0] rdata2, [1] sign-extended inst[15:0], [2] 32'd8, [3] zero-extended inst[15:0]. If no select bit is set, the operand is 0.
- alu_op is one-hot {add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui}:
  - add and sub are mod 2^32 with no overflow trap.
  - slt is signed; sltu is unsigned.
  - shifts shift src2 by src1[4:0]; sra is arithmetic.
  - lui gives {src2[15:0], 16'b0}.
  - If alu_op is all zero, the result is 0.
- `ex_result` is the ALU result.
- Memory request: `data_sram_en`=data_ram_en and `data_sram_wen`=data_ram_wen, both straight from the register. A bubble yields all zero.
- Divider: decodes `div` (opcode 0, func 6'b011010) and `divu` (func 6'b011011) with inst[15:6]=0. States:
  - IDLE: on a div instruction and `stall[2]` permitting, latch operands, take absolute values if signed, set count=0, go to BUSY.
  - BUSY: one restoring-division step per cycle. count increments; after count=31, go to DONE.
  - DONE: apply signs (quotient negative if operand signs differ; remainder takes the dividend's sign). Present lo=quotient, hi=remainder, hilo_we=1. Go to IDLE on the cycle the input register next captures (`stall[2]`=NoStop).
- Divide by zero: lo=32'hFFFF_FFFF, hi=dividend. Full latency still applies.
- `stallreq_for_ex`=1 when (IDLE and div decoded) or BUSY. It is 0 in DONE.

## Timing
- ALU, SRAM request and forwarding bus are combinational from the input register: 1-cycle stage latency.
- Divide latency, with cycle 0 = instruction in EX:
  - stall asserted cycles 0–32 (33 cycles);
  - DONE in cycle 33, result valid on `ex_to_mem_bus`;
  - instruction leaves at the cycle-33 edge if no downstream stall.
- DONE holds its results while `stall[2]`=Stop for downstream reasons.
- Reset values:
  - all outputs 0;
  - FSM IDLE, count 0, divider registers 0.
- `rst` during BUSY aborts: IDLE next cycle, `stallreq_for_ex`=0.
- A bubble arriving in IDLE never starts the divider.
- Back-to-back divides: the second starts from IDLE in the cycle after it is captured.

## Configuration
- `EX_DIV_EN` defined: divider and FSM are compiled in as above.
- `EX_DIV_EN` undefined: div/divu are treated as no-ops. `stallreq_for_ex` is tied 0, and hilo_we, hi and lo are tied 0. `EX_TO_MEM_WD` is unchanged.

## Structure
- `lib/defines.vh` holds:
  - `EX_TO_MEM_WD`=141 and the `ex_to_id` width 38;
  - the alu_op bit indices;
  - the func codes `FUNC_DIV`/`FUNC_DIVU`.
- Sub-module `div_iter`: clk, rst, start, signed_op, dividend, divisor → busy, done, quotient, remainder. It owns the FSM and counter.
- The ALU stays inline.

## Test plan
- `addiu` with rdata1=32'h7FFF_FFFF, imm=16'h0001 → ex_result=32'h8000_0000, rf_we=1, no stall.
- `sw` with rdata1=32'h100, imm=16'hFFFC, rdata2=32'hDEAD_BEEF → data_sram_en=1, wen=4'hF, addr=32'h0FC, wdata=32'hDEAD_BEEF.
- `lw` in EX → inst_is_lw=1, ex_to_id_bus[36:32]=rt. Bubble inserted (stall=6'b000011) → inst_is_lw=0 next cycle.
- `div` with -7 / 2 → stallreq_for_ex high for exactly 33 cycles, then lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF, hilo_we=1.
- `divu` with 32'hFFFF_FFFF / 0 → lo=32'hFFFF_FFFF, hi=32'hFFFF_FFFF, same latency. `rst` asserted at BUSY count 10 → IDLE, stallreq=0 next cycle.
- `stall[2]`=Stop with `stall[3]`=Stop during DONE for 3 cycles → hi/lo held stable, FSM stays DONE until release.
